// File: rtl/hazard_interlock.sv
// Pipeline interlock for the 5-stage RV32 core: ID hazard detection, long-op
// scoreboard, memory-wait freeze, stall statistics and a stall watchdog.
module hazard_interlock #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             ID_branch,
    input  logic             ID_long,
    input  logic             ID_regwrite,
    input  logic             ID_flush,
    input  logic [4:0]       EX_rd,
    input  logic             EX_regwrite,
    input  logic             EX_memread,
    input  logic             EX_long,
    input  logic [4:0]       M_rd,
    input  logic             M_memread,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             mem_busy,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             bubble_EX,
    output logic             freeze,
    output logic [31:0]      sb_pending,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             timeout
);

    localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);

    logic             rs1_ex, rs2_ex, rs1_m, rs2_m;
    logic             load_use, br_hazard, sb_hazard, waw, id_haz;
    logic [31:0]      sb_set, sb_clr, sb_next;
    logic [RUN_W-1:0] run_cnt;

    function automatic logic hit(input logic use_r, input logic [4:0] rs,
                                 input logic [4:0] rd);
        return use_r && (rs != 5'd0) && (rs == rd);
    endfunction

    // Hazard classification; forwarding covers everything not listed here
    always_comb begin
        rs1_ex    = hit(ID_use_rs1, ID_rs1, EX_rd);
        rs2_ex    = hit(ID_use_rs2, ID_rs2, EX_rd);
        rs1_m     = hit(ID_use_rs1, ID_rs1, M_rd);
        rs2_m     = hit(ID_use_rs2, ID_rs2, M_rd);
        load_use  = EX_memread && EX_regwrite && (EX_rd != 5'd0) && (rs1_ex || rs2_ex);
        br_hazard = ID_branch &&
                    ((EX_regwrite && (EX_rd != 5'd0) && (rs1_ex || rs2_ex)) ||
                     (M_memread && (M_rd != 5'd0) && (rs1_m || rs2_m)));
        sb_hazard = (sb_pending[ID_rs1] && ID_use_rs1 && (ID_rs1 != 5'd0)) ||
                    (sb_pending[ID_rs2] && ID_use_rs2 && (ID_rs2 != 5'd0));
        waw       = ID_long && ID_regwrite && (ID_rd != 5'd0) && sb_pending[ID_rd];
        id_haz    = (load_use || br_hazard || sb_hazard || waw) && !ID_flush;
        freeze    = mem_busy;
        stall_IF  = freeze || id_haz;
        stall_ID  = freeze || id_haz;
        bubble_EX = id_haz && !freeze;
    end

    // Set beats a same-cycle clear; writeback clears are never held by freeze
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (EX_long && EX_regwrite && (EX_rd != 5'd0) && !freeze) sb_set[EX_rd] = 1'b1;
        if (wb_valid) sb_clr[wb_rd] = 1'b1;
        sb_next = ((sb_pending & ~sb_clr) | sb_set) & ~32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sb_pending <= '0;
        else     sb_pending <= sb_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       stall_cnt <= '0;
        else if (stall_ID && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
    end

    // Watchdog: run length of consecutive stalls, frozen once it trips
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
            timeout <= 1'b0;
        end else if (!timeout) begin
            if (stall_ID) begin
                run_cnt <= run_cnt + RUN_W'(1);
                if (run_cnt == RUN_W'(TIMEOUT - 1)) timeout <= 1'b1;
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/hazard_interlock.md
# hazard_interlock

Pipeline interlock for the 5-stage RV32 core: it decides when forwarding cannot supply an ID-stage operand and holds the front end. It stalls IF/ID and inserts EX bubbles for load-use and ID-branch hazards. It also keeps a 32-entry scoreboard of registers with outstanding long-latency writes (loads awaiting DM response, divides), freezes the whole pipe on memory wait, and keeps stall statistics plus a stall watchdog. It sits beside the forwarding unit and drives the pipeline-register enables.

## Interface
- CNT_W, 32, width of stall statistics counter
- TIMEOUT, 1024, consecutive stall cycles before watchdog trips
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- ID_rs1, ID_rs2, ID_rd  in  5 each  ID-stage register indices
- ID_use_rs1, ID_use_rs2  in  1 each  ID instruction reads rs1/rs2
- ID_branch  in  1  ID instruction is branch/JALR (operands needed in ID comparator)
- ID_long, ID_regwrite  in  1 each  ID instruction is long-latency op / writes rd
- ID_flush  in  1  ID instruction is being killed this cycle
- EX_rd  in  5  EX-stage destination
- EX_regwrite, EX_memread, EX_long  in  1 each  EX writes rd / is load / is long op
- M_rd  in  5;  M_memread  in  1  M-stage destination / is load
- wb_valid  in  1;  wb_rd  in  5  long-op completion writes wb_rd
- mem_busy  in  1  IM or DM wait
- stall_IF, stall_ID  out  1 each  hold PC / hold IF-ID register
- bubble_EX  out  1  load NOP into ID/EX
- freeze  out  1  hold every pipeline register
- sb_pending  out  32  scoreboard state
- stall_cnt  out  CNT_W  saturating count of stalled cycles
- timeout  out  1  sticky watchdog flag

## Operation
- rsN_hit = ID_use_rsN && ID_rsN != 0 and the index matches.
- load_use: EX_memread && EX_regwrite && EX_rd != 0 && (rs1_hit(EX_rd) || rs2_hit(EX_rd)).
- br_hazard: ID_branch && ((EX_regwrite && EX_rd != 0 && rsN_hit(EX_rd)) || (M_memread && M_rd != 0 && rsN_hit(M_rd))). A load feeding a branch therefore stalls 2 cycles. Forwarding from M covers ALU producers.
- sb_hazard: sb_pending[ID_rs1] && rs1_hit || sb_pending[ID_rs2] && rs2_hit.
- waw: ID_long && ID_regwrite && ID_rd != 0 && sb_pending[ID_rd].
- id_haz = (load_use | br_hazard | sb_hazard | waw) & ~ID_flush.
- freeze = mem_busy.
- stall_IF = stall_ID = freeze | id_haz.
- bubble_EX = id_haz & ~freeze.
- Scoreboard set: EX_long && EX_regwrite && EX_rd != 0 && !freeze sets bit EX_rd.
- Scoreboard clear: wb_valid clears bit wb_rd. It is never blocked by freeze.
- Same-cycle set and clear of the same index: set wins, bit stays 1.
- Bit 0 is never set; it always reads 0.
- stall_cnt increments each cycle stall_ID=1 and saturates at 2^CNT_W-1.
- Watchdog: run counter increments while stall_ID=1 and resets to 0 on any non-stall cycle. When it reaches TIMEOUT, timeout sets and stays set until rst. The run counter then holds.

## Timing
- All stall/bubble/freeze outputs are combinational from inputs and registered sb_pending. There is no added latency.
- Scoreboard, counters and timeout update on the rising clk edge.
- A wb_valid in cycle N clears the bit at the end of N. A dependent ID instruction stalls through N and proceeds in N+1, reading the register file.
- A load-use stall lasts exactly 1 cycle, because the load moves to M.
- rst asserted at any time: sb_pending=0, stall_cnt=0, run counter=0, timeout=0 immediately. Combinational outputs then reflect inputs with an empty scoreboard.
- Reset values with idle inputs: stall_IF=stall_ID=bubble_EX=freeze=0.

## Test plan
- Load-use: EX load x5 (EX_memread=1, EX_rd=5); ID add reads x5 -> stall_ID=1 and bubble_EX=1 for 1 cycle; next cycle (load in M) no stall.
- Load->branch: ID beq x7 with EX load x7 -> stall 2 cycles (EX hit, then M_memread hit); ALU producer x7 in EX -> 1 cycle stall.
- Scoreboard: EX div x9 issued -> sb_pending[9]=1. ID reads x9 -> stall until wb_valid, wb_rd=9 in cycle N; stall_ID=0 in N+1. Same-cycle set/clear of x9 -> bit remains 1.
- Freeze: mem_busy=1 for 3 cycles while EX is div x4 -> freeze=1, bubble_EX=0, sb_pending[4] set only on the first non-frozen cycle; stall_cnt +3.
- Flush/x0: ID_flush=1 with load-use condition -> no stall. Load to x0 followed by a read of x0 -> no stall, sb_pending[0]=0.
- Watchdog/reset: hold sb hazard with TIMEOUT=8 -> timeout=1 after 8 stalled cycles and stays 1 after the hazard clears. Async rst mid-stall -> all registered state 0 without waiting for a clk edge.
